gpio_apb_param: RTL and testbench
=================================

Name: gpio_apb_param

Overview:
Parametrised APB3 GPIO peripheral and the next generation of the 8-pin GPIO slave. Provides N bidirectional pins with per-pin direction, atomic set/clear of outputs, metastability-synchronised inputs, and per-pin rising/falling edge interrupts with W1C status. It sits on the APB bus next to the UART and drives a single level interrupt line to the core.

Parameters:
NUM_PINS, 8, number of GPIO pins (1..32); register bits at and above NUM_PINS read 0, writes to them ignored
SYNC_STAGES, 2, input synchroniser depth in flops (2..4)

Ports:
PCLK  input  1  system clock; all state on rising edge
PRESET  input  1  synchronous active-high reset
PADDR  input  6  byte address; PADDR[5:2] selects the register
PWRITE  input  1  1 = write, 0 = read
PENABLE  input  1  APB access phase
PWDATA  input  32  write data
PSEL  input  1  slave select
PRDATA  output  32  read data, registered
PREADY  output  1  transfer complete, registered
gpio  inout  NUM_PINS  pads
irq  output  1  level interrupt, |(ISR & IER)

Behaviour:
- Reset (synchronous, PRESET high at PCLK edge): every register 0, PRDATA=0, PREADY=0, irq=0, all pads Z, synchroniser flops 0, warm-up counter loaded.
- Register map (offset, access):
  - 0x00 CR, RW: 1 = output.
  - 0x04 ODR, RW.
  - 0x08 IDR, RO: synchronised pad value.
  - 0x0C SET, WO: ODR |= wdata.
  - 0x10 CLR, WO: ODR &= ~wdata.
  - 0x14 IER, RW.
  - 0x18 RISE, RW: rising-edge enable.
  - 0x1C FALL, RW: falling-edge enable.
  - 0x20 ISR, R/W1C.
  - SET, CLR and unmapped offsets read 0. Writes to RO or unmapped offsets are ignored.
- APB handshake, two-state FSM IDLE/ACK:
  - IDLE: if PSEL & PENABLE, go to ACK. The write commits at this edge, or PRDATA is loaded at this edge, and PREADY is set to 1.
  - ACK: PREADY=1 for exactly one cycle, then return to IDLE with PREADY=0.
  - Each access therefore takes one wait state. A write commits exactly once even if PSEL/PENABLE are held through ACK.
- Pad drive: gpio[i] = CR[i] ? ODR[i] : Z. ODR is retained while the pin is an input and drives as soon as CR[i] is set.
- Input path:
  - Pads pass through a SYNC_STAGES flop chain. IDR updates SYNC_STAGES cycles after a pad change.
  - Output pins read back their driven value.
- Edge detect:
  - Compares the synchronised value with its previous-cycle copy.
  - rise[i] = cur & ~prev & RISE[i] & ~CR[i]; fall[i] = ~cur & prev & FALL[i] & ~CR[i].
  - ISR[i] sets the cycle after detection and stays set until cleared.
  - Detection is suppressed for SYNC_STAGES+1 cycles after reset (warm-up counter), so no false edge occurs.
- Simultaneous events: an edge set and a W1C clear of the same ISR bit in one cycle leaves the bit set. A write to ISR with 0 bits has no effect.
- irq is combinational from the ISR/IER registers, so it goes high the cycle ISR sets. Clearing IER masks irq without touching ISR.
- Reset mid-transfer: the FSM returns to IDLE, PREADY=0, and no write commits.

Optional Feature:
GPIO_OPEN_DRAIN_EN
- Defined:
  - Adds register 0x24 ODCR, RW, reset 0.
  - For pins with ODCR[i]=1 and CR[i]=1, gpio[i] = ODR[i] ? Z : 0.
  - Pins with ODCR[i]=0 drive push-pull.
- Undefined: 0x24 reads 0, writes are ignored, and all outputs are push-pull.

Test Plan:
- Reset, then read all registers -> every read 0, gpio all Z, irq=0, PREADY pulses exactly 1 cycle per access.
- Write CR=0xFF, ODR=0xA5, then SET=0x02 and CLR=0x80 -> ODR reads 0x27 and gpio drives 0x27.
- CR=0x00, tb drives gpio=0x3C -> IDR reads 0x3C no earlier than SYNC_STAGES cycles after the drive; gpio stays undriven by the DUT.
- RISE=0x01, FALL=0x02, IER=0x03, pulse pin0 0->1 and pin1 1->0 -> ISR=0x03 and irq=1; write ISR=0x01 -> ISR=0x02, irq still 1; write ISR=0x02 -> irq=0.
- W1C of ISR bit0 in the same cycle as a new pin0 rising edge -> ISR[0] remains 1; pin0 set as output (CR[0]=1) and toggled via ODR -> no ISR set.
- With GPIO_OPEN_DRAIN_EN: CR=0x01, ODCR=0x01, ODR=0x01 -> gpio[0]=Z; ODR=0x00 -> gpio[0]=0.

Source files
------------

// File: rtl/gpio_apb_param_if.sv
// APB3 slave-side bus bundle for the parametrised GPIO block.
interface gpio_apb_param_if;
    logic [5:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/gpio_apb_param.sv
// Parametrised APB3 GPIO: per-pin direction, set/clear, synchronised inputs,
// rise/fall edge interrupts with W1C status and a single level irq.
// Optional open-drain support is enabled by defining GPIO_OPEN_DRAIN_EN.
module gpio_apb_param #(
    parameter int unsigned NUM_PINS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    gpio_apb_param_if.slave     apb,
    inout  wire  [NUM_PINS-1:0] gpio,
    output logic                irq
);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

    state_t              state_q;
    logic [31:0]         prdata_q;
    logic                pready_q;
    logic [NUM_PINS-1:0] cr_q, odr_q, ier_q, rise_q, fall_q, isr_q;
`ifdef GPIO_OPEN_DRAIN_EN
    logic [NUM_PINS-1:0] odcr_q;
`endif
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] prev_q;
    logic [2:0]          warm_q;

    logic [NUM_PINS-1:0] cur, evt, wd, w1c, pad_oe, pad_out;
    logic [3:0]          idx;
    logic                access;
    logic [31:0]         rd_data;
    logic                unused_bits;

    assign access      = apb.PSEL & apb.PENABLE & (state_q == S_IDLE);
    assign idx         = apb.PADDR[5:2];
    assign wd          = apb.PWDATA[NUM_PINS-1:0];
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};
    assign cur         = sync_q[SYNC_STAGES-1];

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign irq         = |(isr_q & ier_q);

    // W1C mask for ISR, only on the committing edge of a write.
    always_comb begin
        w1c = '0;
        if (access && apb.PWRITE && idx == 4'h8) w1c = wd;
    end

    // Edge events on input pins, held off until the synchroniser has filled.
    always_comb begin
        evt = '0;
        if (warm_q == '0)
            evt = ((cur & ~prev_q & rise_q) | (~cur & prev_q & fall_q)) & ~cr_q;
    end

    // Read multiplexer; unmapped and write-only offsets read zero.
    always_comb begin
        rd_data = '0;
        case (idx)
            4'h0:    rd_data[NUM_PINS-1:0] = cr_q;
            4'h1:    rd_data[NUM_PINS-1:0] = odr_q;
            4'h2:    rd_data[NUM_PINS-1:0] = cur;
            4'h5:    rd_data[NUM_PINS-1:0] = ier_q;
            4'h6:    rd_data[NUM_PINS-1:0] = rise_q;
            4'h7:    rd_data[NUM_PINS-1:0] = fall_q;
            4'h8:    rd_data[NUM_PINS-1:0] = isr_q;
`ifdef GPIO_OPEN_DRAIN_EN
            4'h9:    rd_data[NUM_PINS-1:0] = odcr_q;
`endif
            default: rd_data = '0;
        endcase
    end

    // APB IDLE/ACK handshake, register writes and ISR accumulation.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            pready_q <= 1'b0;
            prdata_q <= '0;
            cr_q     <= '0;
            odr_q    <= '0;
            ier_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            isr_q    <= '0;
`ifdef GPIO_OPEN_DRAIN_EN
            odcr_q   <= '0;
`endif
        end else begin
            // A new edge wins over a simultaneous clear of the same bit.
            isr_q <= (isr_q & ~w1c) | evt;
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        state_q  <= S_ACK;
                        pready_q <= 1'b1;
                        if (apb.PWRITE) begin
                            case (idx)
                                4'h0:    cr_q   <= wd;
                                4'h1:    odr_q  <= wd;
                                4'h3:    odr_q  <= odr_q | wd;
                                4'h4:    odr_q  <= odr_q & ~wd;
                                4'h5:    ier_q  <= wd;
                                4'h6:    rise_q <= wd;
                                4'h7:    fall_q <= wd;
`ifdef GPIO_OPEN_DRAIN_EN
                                4'h9:    odcr_q <= wd;
`endif
                                default: ;
                            endcase
                        end else begin
                            prdata_q <= rd_data;
                        end
                    end
                end
                S_ACK: begin
                    state_q  <= S_IDLE;
                    pready_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Input synchroniser chain, previous-value copy and warm-up counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            warm_q <= WARM_CYCLES;
        end else begin
            sync_q[0] <= gpio;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= cur;
            if (warm_q != '0) warm_q <= warm_q - 3'd1;
        end
    end

    // Pad output enable and value; open-drain pins only ever pull low.
    always_comb begin
`ifdef GPIO_OPEN_DRAIN_EN
        pad_oe  = cr_q & ~(odcr_q & odr_q);
        pad_out = odr_q & ~odcr_q;
`else
        pad_oe  = cr_q;
        pad_out = odr_q;
`endif
    end

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign gpio[g] = pad_oe[g] ? pad_out[g] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_apb_param.sv
// Self-checking bench for gpio_apb_param: directed scenarios followed by
// randomised register/pin traffic compared against a register-level model.
// Open-drain checks are included when GPIO_OPEN_DRAIN_EN is defined.
module tb_gpio_apb_param;

    localparam int unsigned NP = 8;
    localparam int unsigned SS = 3;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          irq;
    wire  [NP-1:0] gpio;
    logic [NP-1:0] tb_oe, tb_out, tb_val;

    gpio_apb_param_if apb();

    for (genvar g = 0; g < NP; g++) begin : g_drv
        assign gpio[g] = tb_oe[g] ? tb_out[g] : 1'bz;
    end

    gpio_apb_param #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (apb),
        .gpio   (gpio),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;

    // Register-level model; released open-drain pins are pulled up to 1.
    logic [NP-1:0] m_cr, m_odr, m_ier, m_rise, m_fall, m_isr, m_odcr;
    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] eff_pad();
        return (m_cr & m_odr) | (~m_cr & tb_val);
    endfunction

    function automatic logic [NP-1:0] exp_oe();
`ifdef GPIO_OPEN_DRAIN_EN
        return m_cr & ~(m_odcr & m_odr);
`else
        return m_cr;
`endif
    endfunction

    function automatic logic [NP-1:0] edge_events(input logic [NP-1:0] o, input logic [NP-1:0] n);
        return ((n & ~o & m_rise) | (~n & o & m_fall)) & ~m_cr;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] idx);
        logic [31:0] r;
        r = '0;
        case (idx)
            4'h0: r[NP-1:0] = m_cr;
            4'h1: r[NP-1:0] = m_odr;
            4'h2: r[NP-1:0] = eff_pad();
            4'h5: r[NP-1:0] = m_ier;
            4'h6: r[NP-1:0] = m_rise;
            4'h7: r[NP-1:0] = m_fall;
            4'h8: r[NP-1:0] = m_isr;
`ifdef GPIO_OPEN_DRAIN_EN
            4'h9: r[NP-1:0] = m_odcr;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_cr = '0; m_odr = '0; m_ier = '0; m_rise = '0;
        m_fall = '0; m_isr = '0; m_odcr = '0;
    endtask

    task automatic model_write(input logic [3:0] idx, input logic [31:0] d);
        logic [NP-1:0] v;
        v = d[NP-1:0];
        case (idx)
            4'h0: m_cr   = v;
            4'h1: m_odr  = v;
            4'h3: m_odr  = m_odr | v;
            4'h4: m_odr  = m_odr & ~v;
            4'h5: m_ier  = v;
            4'h6: m_rise = v;
            4'h7: m_fall = v;
            4'h8: m_isr  = m_isr & ~v;
`ifdef GPIO_OPEN_DRAIN_EN
            4'h9: m_odcr = v;
`endif
            default: ;
        endcase
    endtask

    task automatic update_drive();
        tb_oe  = ~exp_oe();
        tb_out = eff_pad();
    endtask

    task automatic settle();
        repeat (SS + 2) @(posedge PCLK);
    endtask

    // One APB transfer; the model is updated just after the committing edge.
    task automatic apb_access(input logic wr, input logic [3:0] idx, input logic [31:0] wdata,
                              input bit hold, output logic [31:0] rdata);
        logic [NP-1:0] old_pad;
        @(negedge PCLK);
        apb.PSEL = 1'b1; apb.PWRITE = wr; apb.PADDR = {idx, 2'b00};
        apb.PWDATA = wdata; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        if (wr) begin
            old_pad = eff_pad();
            model_write(idx, wdata);
            m_isr = m_isr | edge_events(old_pad, eff_pad());
        end
        update_drive();
        @(negedge PCLK);
        check("pready_hi", apb.PREADY, 1'b1);
        rdata = apb.PRDATA;
        if (hold) begin
            @(negedge PCLK);
            check("pready_lo_held", apb.PREADY, 1'b0);
            apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        end else begin
            apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
            @(negedge PCLK);
            check("pready_lo", apb.PREADY, 1'b0);
        end
    endtask

    task automatic check_outputs();
        @(negedge PCLK);
        check("irq", irq, |(m_isr & m_ier));
        check("gpio", gpio, eff_pad());
        check("pad_oe", dut.pad_oe, exp_oe());
    endtask

    task automatic wr_reg(input logic [3:0] idx, input logic [31:0] d, input bit hold = 1'b0);
        logic [31:0] rd;
        apb_access(1'b1, idx, d, hold, rd);
        settle();
        check_outputs();
    endtask

    task automatic rd_reg(input logic [3:0] idx, input string tag);
        logic [31:0] rd;
        apb_access(1'b0, idx, 32'h0, 1'b0, rd);
        check(tag, rd, exp_read(idx));
    endtask

    // Changes the tb-driven pad values; returns the edges the change implies.
    task automatic set_pins_raw(input logic [NP-1:0] v, output logic [NP-1:0] ev);
        logic [NP-1:0] old_pad;
        @(posedge PCLK);
        #1;
        old_pad = eff_pad();
        tb_val  = v;
        update_drive();
        ev = edge_events(old_pad, eff_pad());
    endtask

    task automatic set_pins(input logic [NP-1:0] v);
        logic [NP-1:0] ev;
        set_pins_raw(v, ev);
        m_isr = m_isr | ev;
        settle();
        check_outputs();
    endtask

    task automatic do_reset(input bit quick);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        model_reset();
        update_drive();
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        if (!quick) settle();
    endtask

    initial begin : main
        logic [31:0]   rd;
        logic [NP-1:0] ev, old_pad;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        tb_val = '0;
        model_reset();
        update_drive();

        // Reset state and full register sweep.
        do_reset(1'b0);
        @(negedge PCLK);
        check("pready_rst", apb.PREADY, 1'b0);
        check("prdata_rst", apb.PRDATA, 32'h0);
        check_outputs();
        for (int i = 0; i < 16; i++) rd_reg(4'(i), "rst_read");

        // Output drive with set/clear.
        wr_reg(4'h0, 32'hFF);
        wr_reg(4'h1, 32'hA5);
        wr_reg(4'h3, 32'h02);
        wr_reg(4'h4, 32'h80, 1'b1);
        rd_reg(4'h1, "odr_setclr");
        check("odr_value", exp_read(4'h1), 32'h27);

        // Input path and synchroniser latency.
        wr_reg(4'h0, 32'h00);
        old_pad = eff_pad();
        set_pins_raw(8'h3C, ev);
        m_isr = m_isr | ev;
        repeat (SS - 2) @(posedge PCLK);
        apb_access(1'b0, 4'h2, 32'h0, 1'b0, rd);
        check("idr_early", rd, 32'(old_pad));
        settle();
        rd_reg(4'h2, "idr_3c");
        check_outputs();
        set_pins_raw(8'hC3, ev);
        m_isr = m_isr | ev;
        repeat (SS - 1) @(posedge PCLK);
        apb_access(1'b0, 4'h2, 32'h0, 1'b0, rd);
        check("idr_ontime", rd, 32'hC3);
        settle();

        // Rise/fall interrupts and W1C.
        set_pins(8'h02);
        wr_reg(4'h6, 32'h01);
        wr_reg(4'h7, 32'h02);
        wr_reg(4'h5, 32'h03);
        set_pins(8'h01);
        rd_reg(4'h8, "isr_both");
        wr_reg(4'h8, 32'h01);
        rd_reg(4'h8, "isr_w1c0");
        wr_reg(4'h8, 32'h00);
        rd_reg(4'h8, "isr_w1c_zero");
        wr_reg(4'h8, 32'h02);
        rd_reg(4'h8, "isr_w1c1");

        // Edge set colliding with W1C clear of the same bit.
        set_pins(8'h00);
        set_pins(8'h01);
        rd_reg(4'h8, "isr_pre_collide");
        set_pins(8'h00);
        set_pins_raw(8'h01, ev);
        repeat (SS - 1) @(posedge PCLK);
        apb_access(1'b1, 4'h8, 32'h01, 1'b0, rd);
        m_isr = m_isr | ev;
        settle();
        rd_reg(4'h8, "isr_collide");
        check_outputs();

        // Output pins never raise edge status.
        wr_reg(4'h8, 32'hFF);
        wr_reg(4'h0, 32'h01);
        wr_reg(4'h1, 32'h00);
        wr_reg(4'h1, 32'h01);
        wr_reg(4'h1, 32'h00);
        rd_reg(4'h8, "isr_output_pin");

        // Reset during an access phase: no commit.
        @(negedge PCLK);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 6'h00;
        apb.PWDATA = 32'hFF; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        model_reset();
        update_drive();
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        check("pready_midrst", apb.PREADY, 1'b0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        settle();
        rd_reg(4'h0, "cr_midrst");

        // Warm-up: no false edge while the synchroniser fills after reset.
        tb_val = 8'hFF;
        update_drive();
        settle();
        do_reset(1'b1);
        apb_access(1'b1, 4'h6, 32'hFF, 1'b0, rd);
        settle();
        rd_reg(4'h8, "isr_warmup");

`ifdef GPIO_OPEN_DRAIN_EN
        wr_reg(4'h0, 32'h01);
        wr_reg(4'h9, 32'h01);
        wr_reg(4'h1, 32'h01);
        check("od_released", dut.pad_oe[0], 1'b0);
        wr_reg(4'h1, 32'h00);
        check("od_low", gpio[0], 1'b0);
        rd_reg(4'h9, "odcr");
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 250; n++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                wr_reg(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
            end else if (op <= 6) begin
                rd_reg(4'($urandom_range(0, 15)), "rand_read");
            end else begin
                set_pins(NP'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
